// File: rtl/div_pkg.sv
// Shared state encoding, width constants and the conditional-negate helper
// used by the iterative MIPS DIV/DIVU unit.
package div_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_LATENCY    = DIV_DATA_WIDTH + 2;
  localparam int DIV_MAX_WIDTH  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Two's-complement negate when neg is set; callers truncate to their width.
  function automatic logic [DIV_MAX_WIDTH-1:0] div_cond_neg(
    input logic [DIV_MAX_WIDTH-1:0] v,
    input logic                     neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude and keep the result only when it does not go negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] trial;
  logic       q_bit;

  always_comb begin
    shifted  = {rem, quo[W-1]};
    trial    = shifted - {1'b0, dvsr};
    q_bit    = ~trial[W];
    rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];
    quo_next = {quo[W-2:0], q_bit};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: magnitudes in, DATA_WIDTH restoring iterations,
// one sign fix-up cycle, then a held result under valid/ready backpressure.
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_valid,
  output logic                  div_ready,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  div_cancel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  div_state_t            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_WIDTH-1:0] rem_reg, quo_reg, dvsr_reg, dvnd_reg;
  logic                  q_neg_reg, r_neg_reg, zero_reg;
  logic [DATA_WIDTH-1:0] quotient_reg, remainder_reg;
  logic                  dbz_reg;

  logic                  accept;
  logic                  a_sign, b_sign;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH-1:0] rem_next, quo_next;
  logic [DATA_WIDTH-1:0] quo_fixed, rem_fixed;

  assign accept = (state_reg == IDLE) && div_valid && !div_cancel;

  // DIVU treats operands as raw magnitudes, so both sign flags stay clear.
  assign a_sign = div_signed & dividend[DATA_WIDTH-1];
  assign b_sign = div_signed & divisor[DATA_WIDTH-1];
  assign a_mag  = DATA_WIDTH'(div_cond_neg(DIV_MAX_WIDTH'(dividend), a_sign));
  assign b_mag  = DATA_WIDTH'(div_cond_neg(DIV_MAX_WIDTH'(divisor), b_sign));

  assign quo_fixed = DATA_WIDTH'(div_cond_neg(DIV_MAX_WIDTH'(quo_reg), q_neg_reg));
  assign rem_fixed = DATA_WIDTH'(div_cond_neg(DIV_MAX_WIDTH'(rem_reg), r_neg_reg));

  div_step #(.W(DATA_WIDTH)) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .dvsr     (dvsr_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_comb begin
    state_next = state_reg;
    if (div_cancel) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (div_valid) state_next = CALC;
        CALC:    if (cnt_reg == CNT_LAST) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvsr_reg      <= '0;
      dvnd_reg      <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rem_reg   <= '0;
        quo_reg   <= a_mag;
        dvsr_reg  <= b_mag;
        dvnd_reg  <= dividend;
        q_neg_reg <= a_sign ^ b_sign;
        r_neg_reg <= a_sign;
        zero_reg  <= (divisor == '0);
        cnt_reg   <= '0;
      end else if (state_reg == CALC && !div_cancel) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
      // A flushed operation never reaches the visible result registers.
      if (state_reg == FIX && !div_cancel) begin
        if (zero_reg) begin
          quotient_reg  <= '1;
          remainder_reg <= dvnd_reg;
          dbz_reg       <= 1'b1;
        end else begin
          quotient_reg  <= quo_fixed;
          remainder_reg <= rem_fixed;
          dbz_reg       <= 1'b0;
        end
      end
    end
  end

  assign div_ready   = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: an arithmetic reference model with a timing
// scoreboard checked every cycle, plus hand-computed literal vectors.
module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = 34;
  localparam int NV  = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_valid = 1'b0;
  logic         div_signed = 1'b0;
  logic         div_cancel = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         div_ready, out_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  div_unit #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_valid   (div_valid),
    .div_ready   (div_ready),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .div_cancel  (div_cancel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Directed vectors: dividend, divisor, signed, expected q / r / div_by_zero.
  logic [W-1:0] va [NV] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h12345678, 32'hFFFFFFF9,
                            32'hFFFFFFFF, 32'd5, 32'hFFFFFF9C, 32'hFFFFFFF8, 32'hFFFFFFF9, 32'h80000000};
  logic [W-1:0] vb [NV] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd0,
                            32'd1, 32'd9, 32'hFFFFFFF9, 32'd4, 32'd2, 32'hFFFFFFFF};
  logic         vs [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [W-1:0] vq [NV] = '{32'h0000000E, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'd0, 32'h0000000E, 32'hFFFFFFFE, 32'h7FFFFFFC, 32'd0};
  logic [W-1:0] vr [NV] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h12345678, 32'hFFFFFFF9,
                            32'd0, 32'd5, 32'hFFFFFFFE, 32'd0, 32'd1, 32'h80000000};
  logic         vz [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  // MIPS semantics from plain integer arithmetic: truncating quotient,
  // remainder follows the dividend, divide by zero returns all ones / dividend.
  function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Scoreboard: one outstanding request, result due LAT cycles after accept.
  bit           armed = 1'b0;
  bit           pending = 1'b0;
  int           cyc = 0;
  int           acc = 0;
  logic [W-1:0] mq, mr;
  logic         mz;

  always @(posedge clk) begin
    if (rst) begin
      pending = 1'b0;
      armed   = 1'b1;
    end else if (div_cancel) begin
      pending = 1'b0;
    end else if (!pending) begin
      if (div_valid) begin
        pending = 1'b1;
        acc     = cyc;
        model_div(dividend, divisor, div_signed, mq, mr, mz);
      end
    end else if (cyc >= acc + LAT && out_ready) begin
      pending = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      check("out_valid", 32'(out_valid), 32'(pending && (cyc >= acc + LAT)));
      check("div_ready", 32'(div_ready), 32'(!pending));
      if (pending && (cyc >= acc + LAT)) begin
        check("model_q", quotient, mq);
        check("model_r", remainder, mr);
        check("model_dbz", 32'(div_by_zero), 32'(mz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n = 0;
    while (!div_ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_timeout", 32'(div_ready), 32'd1);
    dividend   = a;
    divisor    = b;
    div_signed = s;
    div_valid  = 1'b1;
    tick();
    div_valid  = 1'b0;
  endtask

  task automatic wait_result(output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("result_timeout", 32'(out_valid), 32'd1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, 32'(div_ready), 32'd1);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_q"}, quotient, 32'd0);
    check({tag, "_r"}, remainder, 32'd0);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  task automatic watch_no_result(input string tag);
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] q, r, pq, pr;
    logic         z, pz;

    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
    tick();

    for (int i = 0; i < NV; i++) begin
      model_div(va[i], vb[i], vs[i], pq, pr, pz);
      check("pin_model_q", pq, vq[i]);
      check("pin_model_r", pr, vr[i]);
      issue(va[i], vb[i], vs[i]);
      wait_result(q, r, z);
      check("vec_q", q, vq[i]);
      check("vec_r", r, vr[i]);
      check("vec_dbz", 32'(z), 32'(vz[i]));
      $display("txn %0d: %s %08h / %08h -> q=%08h r=%08h dbz=%0d", i, vs[i] ? "DIV " : "DIVU",
               va[i], vb[i], q, r, z);
      tick();
    end

    // Backpressure: result must hold for 10 cycles with the unit busy.
    out_ready = 1'b0;
    issue(32'd1000, 32'd3, 1'b0);
    wait_result(q, r, z);
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(div_ready), 32'd0);
      check("bp_q", quotient, 32'h0000014D);
      check("bp_r", remainder, 32'd1);
    end
    $display("txn bp: DIVU 000003e8 / 00000003 -> q=%08h r=%08h held 10 cycles", quotient, remainder);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_release_ready", 32'(div_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    issue(32'd50, 32'd5, 1'b0);
    wait_result(q, r, z);
    check("b2b_q", q, 32'd10);
    check("b2b_r", r, 32'd0);
    $display("txn b2b: DIVU 00000032 / 00000005 -> q=%08h r=%08h", q, r);
    tick();

    // Cancel during CALC at N+10.
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) tick();
    div_cancel = 1'b1;
    tick();
    div_cancel = 1'b0;
    @(negedge clk);
    check("cancel_ready", 32'(div_ready), 32'd1);
    check("cancel_valid", 32'(out_valid), 32'd0);
    watch_no_result("cancel_no_result");
    $display("txn cancel: CALC flush, no result");

    // Cancel together with a request in IDLE.
    tick();
    dividend   = 32'd100;
    divisor    = 32'd7;
    div_signed = 1'b0;
    div_valid  = 1'b1;
    div_cancel = 1'b1;
    tick();
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    @(negedge clk);
    check("cancel_idle_ready", 32'(div_ready), 32'd1);
    watch_no_result("cancel_idle_no_result");
    $display("txn cancel_idle: request dropped");

    // Cancel beats out_ready in DONE.
    tick();
    out_ready = 1'b0;
    issue(32'd77, 32'd7, 1'b0);
    wait_result(q, r, z);
    check("done_q", q, 32'd11);
    check("done_r", r, 32'd0);
    div_cancel = 1'b1;
    out_ready  = 1'b1;
    tick();
    div_cancel = 1'b0;
    @(negedge clk);
    check("cancel_done_valid", 32'(out_valid), 32'd0);
    check("cancel_done_ready", 32'(div_ready), 32'd1);
    $display("txn cancel_done: DIVU 0000004d / 00000007 -> q=%08h flushed", q);

    // Reset at N+5 mid-CALC, then a fresh division.
    tick();
    issue(32'd100, 32'd7, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("midreset");
    tick();
    issue(32'd9, 32'd3, 1'b0);
    wait_result(q, r, z);
    check("post_reset_q", q, 32'd3);
    check("post_reset_r", r, 32'd0);
    $display("txn post_reset: DIVU 00000009 / 00000003 -> q=%08h r=%08h", q, r);
    tick();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
